// File: rtl/ssd_scanner.sv
// Four-digit seven-segment scanner: per-frame digit snapshot, hex decode, one anode per slot.
// Optional leading-zero blanking with `define SSD_LEADING_ZERO_BLANK_EN.
module ssd_scanner #(
  parameter int CLK_DIV      = 100000,
  parameter int COMMON_ANODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] R0,
  input  logic [3:0] R1,
  input  logic [3:0] R2,
  input  logic [3:0] R3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);
  localparam int   CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic INV = (COMMON_ANODE != 0);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0]     cnt, cnt_n;
  logic [1:0]        idx, idx_n;
  logic [3:0][3:0]   sh, sh_n;
  logic              tick, frame;
  logic [6:0]        seg_act;
  logic              blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  assign tick  = en && (cnt == CNT_MAX);
  assign frame = tick && (idx == 2'd3);

  // Outputs are driven from the post-edge slot and shadow values.
  always_comb begin
    cnt_n = cnt;
    idx_n = idx;
    sh_n  = sh;
    if (en) cnt_n = tick ? '0 : cnt + 1'b1;
    if (tick) idx_n = idx + 2'd1;
    if (frame) sh_n = {R3, R2, R1, R0};
  end

  always_comb begin
    seg_act = decode(sh_n[idx_n]);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    // A digit blanks only when it and everything to its left are zero; digit 0 never blanks.
    case (idx_n)
      2'd3:    blank = (sh_n[3] == 4'h0);
      2'd2:    blank = (sh_n[3] == 4'h0) && (sh_n[2] == 4'h0);
      2'd1:    blank = (sh_n[3] == 4'h0) && (sh_n[2] == 4'h0) && (sh_n[1] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    if (blank) seg_act = 7'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      sh         <= '0;
      an         <= {4{INV}};
      seg        <= {7{INV}};
      dp         <= INV;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      dp         <= INV;
      frame_done <= frame;
      if (en) begin
        an  <= INV ? ~(4'b0001 << idx_n) : (4'b0001 << idx_n);
        seg <= INV ? ~seg_act : seg_act;
      end else begin
        an  <= {4{INV}};
        seg <= {7{INV}};
      end
    end
  end
endmodule

// File: tb/tb_ssd_scanner.sv
// Randomized bench for ssd_scanner (CLK_DIV=4, COMMON_ANODE=1) against a cycle-count reference model.
module tb_ssd_scanner;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] R0 = '0, R1 = '0, R2 = '0, R3 = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_done;

  int checks = 0;
  int failures = 0;

  ssd_scanner #(.CLK_DIV(D), .COMMON_ANODE(1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference: n counts enabled cycles since reset; slot = (n/D)%4, frame boundary at n%(4D)==0.
  int         n;
  int         shadow [4];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int k;
    bit blank;
    if (rst) begin
      n = 0;
      for (int i = 0; i < 4; i++) shadow[i] = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else if (en) begin
      n++;
      e_fd = (n % (4 * D)) == 0;
      if (e_fd) begin
        shadow[0] = R0; shadow[1] = R1; shadow[2] = R2; shadow[3] = R3;
      end
      k = (n / D) % 4;
      blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (k > 0) begin
        blank = 1'b1;
        for (int j = k; j < 4; j++) if (shadow[j] != 0) blank = 1'b0;
      end
`endif
      e_an  = ~(4'b0001 << k);
      e_seg = blank ? 7'h7F : ~dec_tbl[shadow[k]];
      e_dp  = 1'b1;
    end else begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end
  endtask

  task automatic step_check(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".an"}, an, e_an);
    chk({tag, ".seg"}, seg, e_seg);
    chk({tag, ".dp"}, dp, e_dp);
    chk({tag, ".fd"}, frame_done, e_fd);
  endtask

  initial begin
    int fd_seen;
    n = 0;
    for (int i = 0; i < 4; i++) shadow[i] = 0;

    // Reset held three cycles, then one idle cycle with en=0.
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) step_check("reset");
    chk("reset.an_const", an, 4'hF);
    chk("reset.seg_const", seg, 7'h7F);
    rst = 1'b0;
    step_check("idle_after_reset");
    chk("idle.an_const", an, 4'hF);

    // Directed scan of 3,3,2,5: first frame zeros, then decoded digits.
    R3 = 4'd3; R2 = 4'd3; R1 = 4'd2; R0 = 4'd5; en = 1'b1;
    fd_seen = 0;
    for (int i = 0; i < 32; i++) begin
      step_check("scan");
      if (i == 15) chk("scan.fd16", frame_done, 1'b1);
      if (i == 1)  chk("scan.first_seg", seg, 7'h40);
      if (i == 17) chk("scan.digit0", seg, 7'h12);
      if (i == 21) chk("scan.digit1", seg, 7'h24);
    end

    // Leading-zero pattern 0,0,7,0 over two frames.
    R3 = 4'd0; R2 = 4'd0; R1 = 4'd7; R0 = 4'd0;
    for (int i = 0; i < 32; i++) step_check("lzb");

    // Mid-frame single-cycle reset.
    rst = 1'b1; step_check("midrst");
    chk("midrst.an_const", an, 4'hF);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step_check("after_midrst");

    // Randomized traffic: en gaps, digit changes mid-frame, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      en  = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 9) < 3) begin
        R0 = 4'($urandom); R1 = 4'($urandom);
        R2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
        R3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      end
      step_check("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
